serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial adder controller that reuses the single-bit halfadder datapath.
//  Two halfadder instances plus an OR form a 1-bit full adder.
//  The controller latches two WIDTH-bit operands and feeds them LSB-first through that cell.
//  It holds the carry in a flop between bits, assembles the sum in a shift register and reports completion with busy/done.
//  It is the sequencer for all multi-bit additions in the q3 datapath.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (legal range 2..32)
// PORTS
//  clk        input   1      rising-edge clock
//  rst        input   1      synchronous reset, active-high
//  start      input   1      request an operation; sampled only in IDLE or DONE
//  a          input   WIDTH  operand A; captured on the accepting edge
//  b          input   WIDTH  operand B; captured on the accepting edge
//  sub        input   1      subtract (A-B) when high; present only with SERIAL_SUB_EN
//  busy       output  1      high while in RUN
//  done       output  1      one-cycle pulse: result valid
//  sum        output  WIDTH  last result; held until the next result lands
//  carry_out  output  1      final carry of last result (with subtract: 1 = no borrow)
// BEHAVIOUR
//  - Reset value: state IDLE; busy=0, done=0, sum=0, carry_out=0; internal shift regs, bit counter and carry flop all 0.
//  - FSM states: IDLE -> RUN -> DONE.
//    - IDLE, start=1: go to RUN. Load opA<=a and opB<=b (or ~b for subtract); cin<=0 (1 for subtract); cnt<=0.
//    - RUN, each edge:
//      - Compute s = opA[0]^opB[0]^cin through the halfadder pair.
//      - cin <= carry from the cell.
//      - sum_sh <= {s, sum_sh[WIDTH-1:1]}; opA and opB shift right by 1; cnt++.
//      - On the edge where cnt==WIDTH-1: go to DONE, sum <= final sum_sh, carry_out <= final carry.
//    - DONE: done=1 for exactly this cycle.
//      - start=1: behave as the IDLE accept (back-to-back op); the next state is RUN.
//      - start=0: go to IDLE.
//  - Latency: start accepted at edge E0. Bits process at edges E1..E(WIDTH).
//    - done is high in the cycle after E(WIDTH); sum/carry_out are valid from then on.
//    - Throughput is one op per WIDTH+1 cycles.
//  - Arithmetic: result is (a+b) mod 2^WIDTH; carry_out = bit WIDTH of the true sum. No sign handling.
//  - start while busy (RUN): ignored; the in-flight op is unaffected and the new operands are not captured.
//  - a/b changing during RUN: no effect (operands are already latched).
//  - rst mid-RUN or in DONE: next cycle is IDLE with all outputs 0; the partial result is discarded and done is not pulsed.
//  - busy and done are never high in the same cycle. The sum/carry_out outputs change only on the edge entering DONE, or on rst.
// CONFIGURATION
//  - SERIAL_SUB_EN defined:
//    - The sub port exists; it is sampled with start.
//    - sub=1: opB <= ~b and initial cin <= 1, giving (a-b) mod 2^WIDTH; carry_out=1 means a>=b.
//    - sub=0: identical to addition.
//  - SERIAL_SUB_EN undefined: the sub port is absent; addition only; initial cin is always 0.
// TESTING
//  1. rst=1 for 2 cycles, then release -> busy=0, done=0, sum=0, carry_out=0; state stays IDLE with start=0.
//  2. WIDTH=4, a=3, b=5, start 1 cycle:
//     - busy for 4 cycles, then done for 1 cycle; sum=8, carry_out=0.
//     - Repeat with a=15, b=1: sum=0, carry_out=1.
//  3. During RUN, pulse start with a=7, b=7 -> ignored; the first op still completes with its own result.
//     After done, no new op starts unless start is high in DONE.
//  4. start held high in DONE with a=9, b=9:
//     - RUN re-entered immediately; the next done gives sum=2, carry_out=1.
//     - Prior result (sum=8) is held through that RUN.
//  5. rst asserted on the 2nd RUN cycle -> IDLE next cycle; outputs 0; no done pulse.
//     A subsequent a=6, b=6 op gives sum=12, carry_out=0.
//  6. SERIAL_SUB_EN: a=5, b=3, sub=1 -> sum=2, carry_out=1.
//     a=3, b=5, sub=1 -> sum=14, carry_out=0.
//     sub=0 with a=3, b=5 -> sum=8.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial A+B (A-B when SERIAL_SUB_EN is defined) through a halfadder-pair full-adder cell.
// Latency: done pulses WIDTH+1 cycles after the accepting edge; one op per WIDTH+1 cycles.
// Backpressure: start is accepted only in IDLE or DONE; requests while busy are dropped.
module serial_adder_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic       sub_w;
  logic       accept;
  logic [1:0] ha0, ha1;
  logic       bit_s, bit_c;

`ifdef SERIAL_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  // Single-bit halfadder cell: {carry, sum}
  function automatic logic [1:0] halfadder(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  assign ha0    = halfadder(opa_q[0], opb_q[0]);
  assign ha1    = halfadder(ha0[0], cin_q);
  assign bit_s  = ha1[0];
  assign bit_c  = ha0[1] | ha1[1];
  assign accept = start && (state_q != RUN);

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sum_sh_d = sum_sh_q;
    cnt_d    = cnt_q;
    cin_d    = cin_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    case (state_q)
      RUN: begin
        cin_d    = bit_c;
        sum_sh_d = (WIDTH-1)'({bit_s, sum_sh_q} >> 1);
        opa_d    = opa_q >> 1;
        opb_d    = opb_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = {bit_s, sum_sh_q};
          cout_d  = bit_c;
        end
      end
      DONE:    state_d = IDLE;
      IDLE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Subtraction is A + ~B + 1: invert B and seed the carry
    if (accept) begin
      state_d = RUN;
      opa_d   = a;
      opb_d   = sub_w ? ~b : b;
      cin_d   = sub_w;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      cin_q    <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sum_sh_q <= sum_sh_d;
      cnt_q    <= cnt_d;
      cin_q    <= cin_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule
